gmii_rx_frame_checker: RTL and testbench
========================================

# gmii_rx_frame_checker

Inline GMII receive checker that sits between the external PHY receive pins of port p1 and the p1 receive input of `time_sensitive_end`, clocked by the PHY receive clock. It forwards the byte stream with a fixed 2-cycle delay and validates every frame: preamble/SFD, length and Ethernet FCS. It asserts the forwarded error line on the last byte of any bad frame, so the downstream receive FIFO drops the frame. It also keeps saturating statistics counters for the host control path.

## Interface
- `MIN_LEN`, 64: minimum legal length in bytes, from the first byte after SFD through the FCS inclusive.
- `MAX_LEN`, 1522: maximum legal length, same definition.
- `CNT_W`, 32: statistics counter width.
- `i_clk`  in  1  GMII receive clock, 125 MHz; the only clock of the block.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_gmii_dv`  in  1  receive data valid from the PHY.
- `iv_gmii_rxd`  in  8  receive data from the PHY.
- `i_gmii_er`  in  1  receive error from the PHY.
- `o_gmii_dv`  out  1  `i_gmii_dv` delayed 2 cycles.
- `ov_gmii_rxd`  out  8  `iv_gmii_rxd` delayed 2 cycles.
- `o_gmii_er`  out  1  `i_gmii_er` delayed 2 cycles, OR'd with the frame-bad flag on the final byte.
- `i_cnt_clr`  in  1  synchronous clear of all counters.
- `ov_frame_cnt`  out  `CNT_W`  number of dv bursts seen.
- `ov_pre_err_cnt`  out  `CNT_W`  preamble/SFD errors.
- `ov_len_err_cnt`  out  `CNT_W`  runt or oversize frames.
- `ov_crc_err_cnt`  out  `CNT_W`  FCS mismatches.
- `o_bad_frame_pulse`  out  1  one-cycle pulse aligned with the output last byte of a bad frame.

## Operation
**Datapath**
- Two register stages, S1 and S2. The outputs are S2.

**Receive FSM (evaluated on S0 = live inputs)**
- IDLE: when dv=1, go to PRE and load `pre_cnt`=1.
  - If the first byte is 0xD5, the SFD is too early: go to PRE_BAD.
  - If the first byte is not 0x55: go to PRE_BAD.
- PRE:
  - byte 0x55 with `pre_cnt` < 7: increment `pre_cnt` and stay.
  - byte 0xD5 with `pre_cnt` in 1..7: go to DATA, CRC register = 0xFFFFFFFF, `len` = 0.
  - any other byte, or an 8th 0x55: go to PRE_BAD.
  - dv=0: go to IDLE and record a preamble error.
- DATA: each byte updates the reflected CRC-32 (polynomial 0xEDB88320, no final inversion) and increments `len`. `len` is 11 bits and saturates at 2047.
- PRE_BAD: pass bytes through and do not check them.
- `rx_er_seen`: a sticky flag, set by `i_gmii_er`=1 while dv=1, in any state.

**End of frame**
- End of frame is the first cycle with dv=0 after dv=1 (cycle E). At E the checker uses the final CRC and length values.
  - `pre_err` = state was PRE or PRE_BAD.
  - `len_err` = DATA and (`len` < `MIN_LEN` or `len` > `MAX_LEN`).
  - `crc_err` = DATA and CRC ≠ 0xDEBB20E3 (residue).
  - `bad` = `pre_err` | `len_err` | `crc_err` | `rx_er_seen`.
- At E, S1 holds the last byte. When that byte moves into S2 at E+1, `o_gmii_er` = S1.er | `bad`, and `o_bad_frame_pulse` = `bad`.
- The FSM returns to IDLE at E, and the flags clear at E.

**Counters**
- At E+1, `ov_frame_cnt` increments.
- At E+1, each of `ov_pre_err_cnt`, `ov_len_err_cnt` and `ov_crc_err_cnt` increments independently when its flag is set. `rx_er_seen` alone increments none of the error counters.
- All counters saturate at 2^`CNT_W`−1.
- `i_cnt_clr`=1 zeroes all counters on the next edge. Clear wins over a coincident increment, and that event is lost.

## Timing
- Reset: all outputs 0, FSM in IDLE, S1/S2 zeroed, counters 0, CRC register 0xFFFFFFFF.
- Latency from input to output is exactly 2 cycles for dv, rxd and er. Error flagging adds no latency.
- The minimum supported inter-frame gap is 1 dv-low cycle. A following frame starting at E+1 is checked independently.
- A dv burst with no gap is one frame.
- Reset mid-frame: outputs drop to 0 at once. The partial frame is neither counted nor flagged, and the next dv rise starts a fresh frame.
- A frame of 1 byte (dv high for 1 cycle) counts as a frame with a preamble error.

## Test plan
- Good frame: 7×0x55, 0xD5, 60-byte payload, correct FCS (64 bytes) → output identical delayed 2 cycles, `o_gmii_er`=0 throughout, `ov_frame_cnt`=1, error counters 0.
- Bad FCS: same frame with its last FCS byte XOR 0x01 → `o_gmii_er`=1 only on the output last byte, `o_bad_frame_pulse` pulse 1 cycle, `ov_crc_err_cnt`=1.
- Length errors:
  - 40-byte frame with valid FCS → `ov_len_err_cnt`=1, CRC count 0.
  - 1530-byte frame → `ov_len_err_cnt`=2.
- Preamble errors:
  - frame with SFD replaced by 0x55 → `ov_pre_err_cnt`=1.
  - SFD as the first byte → `ov_pre_err_cnt`=2.
  - PHY `i_gmii_er`=1 for one payload byte in a good-FCS frame → er passes through delayed, last byte flagged, no error counter change.
- Back-to-back: two good 64-byte frames separated by 1 dv-low cycle → both pass with no flagging, `ov_frame_cnt`=2.
- Clear/saturation/reset:
  - with `CNT_W`=4, 16 CRC-error frames → `ov_crc_err_cnt` holds 15.
  - `i_cnt_clr` coincident with the end of a frame → all counters read 0.
  - `i_rst` asserted mid-payload → outputs 0 immediately, and the next good frame is clean.

Source files
------------

// File: rtl/gmii_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// gmii_rx_frame_checker
//
// Inline GMII receive checker. The PHY byte stream passes through two register
// stages (S1, S2) unchanged, so every output lags its input by exactly 2
// cycles. Each frame is validated from the live inputs: preamble/SFD, length
// (first byte after SFD through FCS) and the Ethernet FCS via the CRC-32
// residue. On a bad frame the forwarded error line is raised on the last
// byte, so the downstream FIFO drops the frame. Saturating statistics
// counters serve the host control path.
//
// Ports
//   i_clk, i_rst                 GMII receive clock, async active-high reset
//   i_gmii_dv/iv_gmii_rxd/i_gmii_er   PHY receive stream
//   o_gmii_dv/ov_gmii_rxd/o_gmii_er   forwarded stream (2-cycle delay)
//   i_cnt_clr                    synchronous clear of all counters
//   ov_frame_cnt                 dv bursts seen
//   ov_pre_err_cnt               preamble/SFD errors
//   ov_len_err_cnt               runt or oversize frames
//   ov_crc_err_cnt               FCS mismatches
//   o_bad_frame_pulse            pulse aligned with output last byte of a bad frame
// -----------------------------------------------------------------------------
module gmii_rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gmii_dv,
    input  logic [7:0]       iv_gmii_rxd,
    input  logic             i_gmii_er,
    output logic             o_gmii_dv,
    output logic [7:0]       ov_gmii_rxd,
    output logic             o_gmii_er,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] ov_frame_cnt,
    output logic [CNT_W-1:0] ov_pre_err_cnt,
    output logic [CNT_W-1:0] ov_len_err_cnt,
    output logic [CNT_W-1:0] ov_crc_err_cnt,
    output logic             o_bad_frame_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PRE_BAD
    } state_t;

    localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0]      LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0]      LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0]      LEN_SAT     = 11'h7FF;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Reflected CRC-32, one byte per call, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // S1 stage; S2 is the output registers themselves.
    logic        s1_dv;
    logic [7:0]  s1_rxd;
    logic        s1_er;

    state_t      state, state_d;
    logic [2:0]  pre_cnt, pre_cnt_d;
    logic [31:0] crc, crc_d;
    logic [10:0] len, len_d;
    logic        er_seen, er_seen_d;

    logic        eof;
    logic        pre_err, len_err, crc_err, bad;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state;
        pre_cnt_d = pre_cnt;
        crc_d     = crc;
        len_d     = len;
        er_seen_d = er_seen | (i_gmii_dv & i_gmii_er);

        // End of frame: first dv-low cycle after a dv-high one.
        eof     = s1_dv & ~i_gmii_dv;
        pre_err = eof & ((state == ST_PRE) || (state == ST_PRE_BAD));
        len_err = eof & (state == ST_DATA) & ((len < LEN_MIN) || (len > LEN_MAX));
        crc_err = eof & (state == ST_DATA) & (crc != CRC_RESIDUE);
        bad     = pre_err | len_err | crc_err | (eof & er_seen);

        unique case (state)
            ST_IDLE: begin
                if (i_gmii_dv) begin
                    pre_cnt_d = 3'd1;
                    state_d   = (iv_gmii_rxd == 8'h55) ? ST_PRE : ST_PRE_BAD;
                end
            end
            ST_PRE: begin
                if (!i_gmii_dv) begin
                    state_d = ST_IDLE;
                end else if (iv_gmii_rxd == 8'h55 && pre_cnt < 3'd7) begin
                    pre_cnt_d = pre_cnt + 3'd1;
                end else if (iv_gmii_rxd == 8'hD5) begin
                    // pre_cnt is always 1..7 here, so the SFD is in range.
                    state_d = ST_DATA;
                    crc_d   = CRC_INIT;
                    len_d   = 11'd0;
                end else begin
                    state_d = ST_PRE_BAD;
                end
            end
            ST_DATA: begin
                if (!i_gmii_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    crc_d = crc32_byte(crc, iv_gmii_rxd);
                    len_d = (len == LEN_SAT) ? len : len + 11'd1;
                end
            end
            ST_PRE_BAD: begin
                if (!i_gmii_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (eof) er_seen_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            pre_cnt <= 3'd0;
            crc     <= CRC_INIT;
            len     <= 11'd0;
            er_seen <= 1'b0;
        end else begin
            state   <= state_d;
            pre_cnt <= pre_cnt_d;
            crc     <= crc_d;
            len     <= len_d;
            er_seen <= er_seen_d;
        end
    end

    // Datapath: bad is only ever set at end of frame, when S1 holds the last
    // byte, so the flag lands on that byte as it moves into S2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_dv             <= 1'b0;
            s1_rxd            <= 8'h00;
            s1_er             <= 1'b0;
            o_gmii_dv         <= 1'b0;
            ov_gmii_rxd       <= 8'h00;
            o_gmii_er         <= 1'b0;
            o_bad_frame_pulse <= 1'b0;
        end else begin
            s1_dv             <= i_gmii_dv;
            s1_rxd            <= iv_gmii_rxd;
            s1_er             <= i_gmii_er;
            o_gmii_dv         <= s1_dv;
            ov_gmii_rxd       <= s1_rxd;
            o_gmii_er         <= s1_er | bad;
            o_bad_frame_pulse <= bad;
        end
    end

    // Clear has priority; an increment on the same edge is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_frame_cnt   <= '0;
            ov_pre_err_cnt <= '0;
            ov_len_err_cnt <= '0;
            ov_crc_err_cnt <= '0;
        end else if (i_cnt_clr) begin
            ov_frame_cnt   <= '0;
            ov_pre_err_cnt <= '0;
            ov_len_err_cnt <= '0;
            ov_crc_err_cnt <= '0;
        end else begin
            if (eof)     ov_frame_cnt   <= sat_inc(ov_frame_cnt);
            if (pre_err) ov_pre_err_cnt <= sat_inc(ov_pre_err_cnt);
            if (len_err) ov_len_err_cnt <= sat_inc(ov_len_err_cnt);
            if (crc_err) ov_crc_err_cnt <= sat_inc(ov_crc_err_cnt);
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_gmii_rx_frame_checker
//
// Frames are built as byte lists; their verdict (preamble shape, length, FCS
// against a freshly computed CRC, PHY error) is derived per frame and turned
// into the expected forwarded stream and counter totals. A second instance
// with 4-bit counters shares the inputs and shows counter saturation.
// -----------------------------------------------------------------------------
module tb_gmii_rx_frame_checker;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_gmii_dv;
    logic [7:0]  iv_gmii_rxd;
    logic        i_gmii_er;
    logic        i_cnt_clr;

    logic        o_gmii_dv, o_gmii_er, o_bad_frame_pulse;
    logic [7:0]  ov_gmii_rxd;
    logic [31:0] ov_frame_cnt, ov_pre_err_cnt, ov_len_err_cnt, ov_crc_err_cnt;

    logic        d4_dv, d4_er, d4_pulse;
    logic [7:0]  d4_rxd;
    logic [3:0]  d4_frame, d4_pre, d4_len, d4_crc;

    always #4 i_clk = ~i_clk;

    gmii_rx_frame_checker dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_gmii_dv(i_gmii_dv), .iv_gmii_rxd(iv_gmii_rxd), .i_gmii_er(i_gmii_er),
        .o_gmii_dv(o_gmii_dv), .ov_gmii_rxd(ov_gmii_rxd), .o_gmii_er(o_gmii_er),
        .i_cnt_clr(i_cnt_clr),
        .ov_frame_cnt(ov_frame_cnt), .ov_pre_err_cnt(ov_pre_err_cnt),
        .ov_len_err_cnt(ov_len_err_cnt), .ov_crc_err_cnt(ov_crc_err_cnt),
        .o_bad_frame_pulse(o_bad_frame_pulse)
    );

    gmii_rx_frame_checker #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_gmii_dv(i_gmii_dv), .iv_gmii_rxd(iv_gmii_rxd), .i_gmii_er(i_gmii_er),
        .o_gmii_dv(d4_dv), .ov_gmii_rxd(d4_rxd), .o_gmii_er(d4_er),
        .i_cnt_clr(i_cnt_clr),
        .ov_frame_cnt(d4_frame), .ov_pre_err_cnt(d4_pre),
        .ov_len_err_cnt(d4_len), .ov_crc_err_cnt(d4_crc),
        .o_bad_frame_pulse(d4_pulse)
    );

    int tests = 0;
    int fails = 0;

    // Expected {dv, rxd, er, pulse} driven one and two steps ago.
    logic [10:0] p0, p1;

    logic [7:0] fr[$];
    bit         fe[$];

    logic [31:0] m_frame, m_pre, m_len, m_crc;
    logic [3:0]  m4_frame, m4_pre, m4_len, m4_crc;

    function automatic logic [31:0] crc_range(int from, int to);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = from; i <= to; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // pre_n preamble bytes, SFD, pay_n random bytes, FCS (optionally corrupted).
    task automatic build_frame(int pre_n, int pay_n, bit corrupt);
        logic [31:0] fcs;
        int          first;
        fr.delete();
        fe.delete();
        for (int i = 0; i < pre_n; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        first = fr.size();
        for (int i = 0; i < pay_n; i++) fr.push_back(8'($urandom_range(0, 255)));
        fcs = ~crc_range(first, fr.size() - 1);
        fr.push_back(fcs[7:0]);
        fr.push_back(fcs[15:8]);
        fr.push_back(fcs[23:16]);
        fr.push_back(fcs[31:24]);
        if (corrupt) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
        for (int i = 0; i < fr.size(); i++) fe.push_back(1'b0);
    endtask

    task automatic frame_verdict(output bit pre_e, output bit len_e,
                                 output bit crc_e, output bit bad);
        int k = 0;
        int n, sz;
        bit er_any = 0;
        logic [31:0] fcs_rx;
        sz = fr.size();
        while (k < sz && fr[k] == 8'h55) k++;
        pre_e = !(k >= 1 && k <= 7 && k < sz && fr[k] == 8'hD5);
        n     = sz - k - 1;
        len_e = !pre_e && (n < 64 || n > 1522);
        crc_e = 0;
        if (!pre_e && n >= 4) begin
            fcs_rx = {fr[sz-1], fr[sz-2], fr[sz-3], fr[sz-4]};
            crc_e  = (fcs_rx != ~crc_range(k + 1, sz - 5));
        end
        foreach (fe[i]) er_any |= fe[i];
        bad = pre_e | len_e | crc_e | er_any;
    endtask

    // One cycle: check forwarded stream against the item from 2 steps ago,
    // then drive the next input.
    task automatic step(bit dv, logic [7:0] rxd, bit er, bit exp_er, bit exp_pulse, bit clr);
        @(negedge i_clk);
        tests++;
        if ({o_gmii_dv, ov_gmii_rxd, o_gmii_er, o_bad_frame_pulse} !== p1 ||
            {d4_dv, d4_rxd, d4_er, d4_pulse} !== p1) begin
            fails++;
            $display("FAIL stream t=%0t got=%h got4=%h exp=%h", $time,
                     {o_gmii_dv, ov_gmii_rxd, o_gmii_er, o_bad_frame_pulse},
                     {d4_dv, d4_rxd, d4_er, d4_pulse}, p1);
        end
        p1 = p0;
        p0 = {dv, rxd, exp_er, exp_pulse};
        i_gmii_dv   = dv;
        iv_gmii_rxd = rxd;
        i_gmii_er   = er;
        i_cnt_clr   = clr;
    endtask

    task automatic idle(int n, bit clr = 0);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, clr);
    endtask

    task automatic zero_models();
        {m_frame, m_pre, m_len, m_crc} = '0;
        {m4_frame, m4_pre, m4_len, m4_crc} = '0;
    endtask

    task automatic send_frame(int gap, bit clr_at_end = 0);
        bit pre_e, len_e, crc_e, bad;
        int last;
        frame_verdict(pre_e, len_e, crc_e, bad);
        last = fr.size() - 1;
        for (int i = 0; i <= last; i++)
            step(1, fr[i], fe[i], fe[i] | (i == last && bad), (i == last && bad), 0);
        for (int g = 0; g < gap; g++) step(0, 8'h00, 0, 0, 0, clr_at_end && g == 0);
        if (clr_at_end) begin
            zero_models();
        end else begin
            m_frame = (m_frame == '1) ? m_frame : m_frame + 1;
            if (pre_e) m_pre = (m_pre == '1) ? m_pre : m_pre + 1;
            if (len_e) m_len = (m_len == '1) ? m_len : m_len + 1;
            if (crc_e) m_crc = (m_crc == '1) ? m_crc : m_crc + 1;
            m4_frame = (m4_frame == 4'hF) ? m4_frame : m4_frame + 4'd1;
            if (pre_e) m4_pre = (m4_pre == 4'hF) ? m4_pre : m4_pre + 4'd1;
            if (len_e) m4_len = (m4_len == 4'hF) ? m4_len : m4_len + 4'd1;
            if (crc_e) m4_crc = (m4_crc == 4'hF) ? m4_crc : m4_crc + 4'd1;
        end
    endtask

    task automatic clear_counters();
        idle(1, 1);
        zero_models();
        idle(1);
    endtask

    task automatic test_reset();
        i_rst = 1; i_gmii_dv = 0; iv_gmii_rxd = 0; i_gmii_er = 0; i_cnt_clr = 0;
        p0 = '0; p1 = '0;
        zero_models();
        #1;
        tests++;
        if ({o_gmii_dv, ov_gmii_rxd, o_gmii_er, o_bad_frame_pulse, ov_frame_cnt,
             ov_pre_err_cnt, ov_len_err_cnt, ov_crc_err_cnt, d4_frame, d4_crc} !== '0) begin
            fails++;
            $display("FAIL reset_state got dv=%b rxd=%h er=%b frame=%0d crc=%0d exp all 0",
                     o_gmii_dv, ov_gmii_rxd, o_gmii_er, ov_frame_cnt, ov_crc_err_cnt);
        end
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 0;
        idle(3);
    endtask

    // Counter comparison, written out per test.
`define CHECK_COUNTERS(NAME) \
        tests++; \
        if ({ov_frame_cnt, ov_pre_err_cnt, ov_len_err_cnt, ov_crc_err_cnt} !== {m_frame, m_pre, m_len, m_crc} || \
            {d4_frame, d4_pre, d4_len, d4_crc} !== {m4_frame, m4_pre, m4_len, m4_crc}) begin \
            fails++; \
            $display("FAIL %s counters got=%0d/%0d/%0d/%0d (w4 %0d/%0d/%0d/%0d) exp=%0d/%0d/%0d/%0d (w4 %0d/%0d/%0d/%0d)", NAME, \
                     ov_frame_cnt, ov_pre_err_cnt, ov_len_err_cnt, ov_crc_err_cnt, d4_frame, d4_pre, d4_len, d4_crc, \
                     m_frame, m_pre, m_len, m_crc, m4_frame, m4_pre, m4_len, m4_crc); \
        end

    task automatic test_good_frame();
        build_frame(7, 60, 0);
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("good_frame")
    endtask

    task automatic test_bad_fcs();
        build_frame(7, 60, 1);
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("bad_fcs")
    endtask

    task automatic test_length();
        build_frame(7, 36, 0);
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("runt")
        build_frame(7, 1526, 0);
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("oversize")
    endtask

    task automatic test_preamble();
        build_frame(7, 60, 0);
        fr[7] = 8'h55;              // SFD replaced: eight 0x55 in a row
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("sfd_missing")
        build_frame(7, 60, 0);
        for (int i = 0; i < 7; i++) begin
            void'(fr.pop_front());
            void'(fe.pop_front());
        end
        send_frame(2);              // SFD as the very first byte
        idle(3);
        `CHECK_COUNTERS("sfd_first")
        fr.delete(); fe.delete();
        fr.push_back(8'h55); fe.push_back(1'b0);
        send_frame(1);              // single-byte burst
        build_frame(1, 60, 0);      // shortest legal preamble
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("one_byte_and_short_pre")
    endtask

    task automatic test_phy_er();
        build_frame(7, 60, 0);
        fe[20] = 1'b1;
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("phy_er")
    endtask

    task automatic test_back_to_back();
        build_frame(7, 60, 0);
        send_frame(1);
        build_frame(7, 60, 0);
        send_frame(1);
        build_frame(7, 60, 1);
        send_frame(1);
        idle(3);
        `CHECK_COUNTERS("back_to_back")
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            build_frame(($urandom_range(0, 5) == 0) ? 8 : $urandom_range(1, 7),
                        $urandom_range(40, 90), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) fe[$urandom_range(0, fe.size() - 1)] = 1'b1;
            send_frame($urandom_range(1, 3));
        end
        idle(3);
        `CHECK_COUNTERS("random")
    endtask

    task automatic test_clear_at_eof();
        build_frame(7, 60, 1);
        send_frame(2, 1);
        idle(3);
        `CHECK_COUNTERS("clear_at_eof")
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int f = 0; f < 16; f++) begin
            build_frame(7, 60, 1);
            send_frame(1);
        end
        idle(3);
        `CHECK_COUNTERS("saturation")
        tests++;
        if (d4_crc !== 4'hF) begin
            fails++;
            $display("FAIL sat_crc4 got=%0d exp=15", d4_crc);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(7, 60, 0);
        for (int i = 0; i < 30; i++) step(1, fr[i], 0, 0, 0, 0);
        #2;
        i_rst = 1;
        i_gmii_dv = 0; iv_gmii_rxd = 0; i_gmii_er = 0;
        #1;
        tests++;
        if ({o_gmii_dv, ov_gmii_rxd, o_gmii_er, o_bad_frame_pulse, d4_dv, d4_rxd} !== '0) begin
            fails++;
            $display("FAIL reset_mid_frame outputs got dv=%b rxd=%h er=%b exp 0",
                     o_gmii_dv, ov_gmii_rxd, o_gmii_er);
        end
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 0;
        p0 = '0; p1 = '0;
        zero_models();
        idle(2);
        build_frame(7, 60, 0);
        send_frame(2);
        idle(3);
        `CHECK_COUNTERS("after_reset")
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_length();
        test_preamble();
        test_phy_er();
        test_back_to_back();
        test_random();
        test_clear_at_eof();
        test_saturation();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
